// File: rtl/synth_reg_pkg.sv
// synth_reg_pkg: register map, reset values and requester IDs shared by synth_reg_arbiter.
package synth_reg_pkg;
    localparam logic [7:0] ADDR_CONTROL  = 8'h00;
    localparam logic [7:0] ADDR_FREQ_LO  = 8'h02;
    localparam logic [7:0] ADDR_FREQ_MID = 8'h03;
    localparam logic [7:0] ADDR_FREQ_HI  = 8'h04;
    localparam logic [7:0] ADDR_DUTY     = 8'h05;
    localparam logic [7:0] ADDR_VOLUME   = 8'h06;
    localparam logic [7:0] ADDR_STATUS   = 8'h12;
    localparam logic [7:0]  RST_CONTROL = 8'h1C;
    localparam logic [23:0] RST_FREQ    = 24'h000000;
    localparam logic [7:0]  RST_DUTY    = 8'h80;
    localparam logic [7:0]  RST_VOLUME  = 8'hFF;
    typedef enum logic {
        PORT_HOST = 1'b0,
        PORT_SEQ  = 1'b1
    } port_e;
endpackage

// File: rtl/synth_reg_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin grant; the host wins ties after reset.
module rr_arb2
    import synth_reg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_host,
    input  logic req_seq,
    output logic gnt_host,
    output logic gnt_seq
);
    port_e last_grant_q, last_grant_d;

    always_comb begin
        gnt_host = !rst && req_host && (!req_seq || last_grant_q == PORT_SEQ);
        gnt_seq = !rst && req_seq && !gnt_host;
        last_grant_d = gnt_host ? PORT_HOST : gnt_seq ? PORT_SEQ : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) last_grant_q <= PORT_SEQ;
        else last_grant_q <= last_grant_d;
    end
endmodule

// File: rtl/synth_reg_arbiter.sv
// synth_reg_arbiter: arbitrates host/sequencer register writes into the synth register bank.
// SYNTH_ARB_FREQ_ATOMIC_EN: per-port low/mid shadows, 24-bit frequency committed on the high-byte write.
module synth_reg_arbiter
    import synth_reg_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int SEQ_GATE_BIT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_data,
    output logic              host_ready,
    input  logic              seq_valid,
    input  logic [ADDR_W-1:0] seq_addr,
    input  logic [7:0]        seq_data,
    output logic              seq_ready,
    output logic [7:0]        reg_control,
    output logic [23:0]       reg_freq,
    output logic [7:0]        reg_duty,
    output logic [7:0]        reg_volume,
    output logic              freq_update,
    output logic              wr_grant_host
);
    logic              gnt_host, gnt_seq, wr_en, hit_lo, hit_mid, hit_hi;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        control_q, control_d, duty_q, duty_d, volume_q, volume_d;
    logic [23:0]       freq_q, freq_d;
    logic              freq_update_q, freq_update_d, wr_grant_host_q, wr_grant_host_d;

    // The gate uses the registered control byte, so a clearing write blocks seq from the next cycle.
    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_host (host_valid),
        .req_seq  (seq_valid & control_q[SEQ_GATE_BIT]),
        .gnt_host (gnt_host),
        .gnt_seq  (gnt_seq)
    );

    assign host_ready = gnt_host;
    assign seq_ready  = gnt_seq;
    assign wr_en      = gnt_host | gnt_seq;
    assign wr_addr    = gnt_host ? host_addr : seq_addr;
    assign wr_data    = gnt_host ? host_data : seq_data;
    assign hit_lo     = wr_en && wr_addr == ADDR_W'(ADDR_FREQ_LO);
    assign hit_mid    = wr_en && wr_addr == ADDR_W'(ADDR_FREQ_MID);
    assign hit_hi     = wr_en && wr_addr == ADDR_W'(ADDR_FREQ_HI);

`ifdef SYNTH_ARB_FREQ_ATOMIC_EN
    port_e           wr_port;
    logic [1:0][7:0] shadow_lo_q, shadow_lo_d, shadow_mid_q, shadow_mid_d;
    assign wr_port = gnt_host ? PORT_HOST : PORT_SEQ;
`endif

    always_comb begin
        control_d = (wr_en && wr_addr == ADDR_W'(ADDR_CONTROL)) ? wr_data : control_q;
        duty_d = (wr_en && wr_addr == ADDR_W'(ADDR_DUTY)) ? wr_data : duty_q;
        volume_d = (wr_en && wr_addr == ADDR_W'(ADDR_VOLUME)) ? wr_data : volume_q;
        wr_grant_host_d = wr_en ? gnt_host : wr_grant_host_q;
`ifdef SYNTH_ARB_FREQ_ATOMIC_EN
        shadow_lo_d = shadow_lo_q;
        shadow_mid_d = shadow_mid_q;
        if (hit_lo) shadow_lo_d[wr_port] = wr_data;
        if (hit_mid) shadow_mid_d[wr_port] = wr_data;
        freq_update_d = hit_hi;
        freq_d = hit_hi ? {wr_data, shadow_mid_q[wr_port], shadow_lo_q[wr_port]} : freq_q;
`else
        freq_d = freq_q;
        if (hit_lo) freq_d[7:0] = wr_data;
        if (hit_mid) freq_d[15:8] = wr_data;
        if (hit_hi) freq_d[23:16] = wr_data;
        freq_update_d = hit_lo || hit_mid || hit_hi;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            control_q       <= RST_CONTROL;
            freq_q          <= RST_FREQ;
            duty_q          <= RST_DUTY;
            volume_q        <= RST_VOLUME;
            freq_update_q   <= 1'b0;
            wr_grant_host_q <= 1'b0;
`ifdef SYNTH_ARB_FREQ_ATOMIC_EN
            shadow_lo_q     <= '0;
            shadow_mid_q    <= '0;
`endif
        end else begin
            control_q       <= control_d;
            freq_q          <= freq_d;
            duty_q          <= duty_d;
            volume_q        <= volume_d;
            freq_update_q   <= freq_update_d;
            wr_grant_host_q <= wr_grant_host_d;
`ifdef SYNTH_ARB_FREQ_ATOMIC_EN
            shadow_lo_q     <= shadow_lo_d;
            shadow_mid_q    <= shadow_mid_d;
`endif
        end
    end

    assign reg_control   = control_q;
    assign reg_freq      = freq_q;
    assign reg_duty      = duty_q;
    assign reg_volume    = volume_q;
    assign freq_update   = freq_update_q;
    assign wr_grant_host = wr_grant_host_q;
endmodule
